// File: rtl/rv_defines.sv
// rv_defines: shared bypass select and pipeline stage-entry types
package rv_defines;
    localparam int RV_REG_W = 5;
    typedef struct packed {
        logic alu2;
        logic write;
        logic wr_back;
    } ctrl_rs_bp_t;
    typedef struct packed {
        logic                valid;
        logic [RV_REG_W-1:0] rd;
        logic                load;
    } bp_entry_t;
    function automatic logic entry_match(input logic [RV_REG_W-1:0] rs, input bp_entry_t e);
        return (rs != '0) && e.valid && (e.rd == rs);
    endfunction
endpackage

// File: rtl/rv_bypass_match.sv
// rv_bypass_match: maps one source register against the three in-flight writers to a bypass select
module rv_bypass_match
    import rv_defines::*;
(
    input  logic [RV_REG_W-1:0] i_rs,
    input  bp_entry_t           i_alu1,
    input  bp_entry_t           i_alu2,
    input  bp_entry_t           i_wr,
    output ctrl_rs_bp_t         o_sel,
    output logic                o_load_hit
);
    logic m_alu1, m_alu2, m_wr;
    assign m_alu1 = entry_match(i_rs, i_alu1);
    assign m_alu2 = entry_match(i_rs, i_alu2);
    assign m_wr   = entry_match(i_rs, i_wr);
    // youngest producer wins
    always_comb begin
        o_sel.alu2    = m_alu1;
        o_sel.write   = !m_alu1 && m_alu2;
        o_sel.wr_back = !m_alu1 && !m_alu2 && m_wr;
    end
    assign o_load_hit = m_alu1 && i_alu1.load;
endmodule

// File: rtl/rv_bypass_ctrl.sv
// rv_bypass_ctrl: operand bypass select and load-use stall for the alu1 operands
module rv_bypass_ctrl
    import rv_defines::*;
#(
    parameter int REG_W = RV_REG_W
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_dec_valid,
    input  logic [REG_W-1:0] i_dec_rs1,
    input  logic [REG_W-1:0] i_dec_rs2,
    input  logic [REG_W-1:0] i_dec_rd,
    input  logic             i_dec_rd_wr,
    input  logic             i_dec_load,
    input  logic             i_hold,
    input  logic             i_flush,
    output ctrl_rs_bp_t      o_bp1,
    output ctrl_rs_bp_t      o_bp2,
    output logic             o_stall
);
    bp_entry_t   alu1_q, alu1_d, alu2_q, alu2_d, wr_q, wr_d, dec_e;
    ctrl_rs_bp_t bp1_q, bp1_d, bp2_q, bp2_d, sel1, sel2;
    logic        hit1, hit2, bubble;

    rv_bypass_match u_m1 (
        .i_rs(i_dec_rs1), .i_alu1(alu1_q), .i_alu2(alu2_q), .i_wr(wr_q),
        .o_sel(sel1), .o_load_hit(hit1)
    );
    rv_bypass_match u_m2 (
        .i_rs(i_dec_rs2), .i_alu1(alu1_q), .i_alu2(alu2_q), .i_wr(wr_q),
        .o_sel(sel2), .o_load_hit(hit2)
    );

    assign o_stall = i_dec_valid && !i_flush && (hit1 || hit2);
    assign bubble  = i_flush || o_stall || !i_dec_valid;

    always_comb begin
        dec_e.valid = !bubble && i_dec_rd_wr && (i_dec_rd != '0);
        dec_e.rd    = i_dec_rd;
        dec_e.load  = i_dec_load;
        alu1_d      = alu1_q;
        alu2_d      = alu2_q;
        wr_d        = wr_q;
        bp1_d       = bp1_q;
        bp2_d       = bp2_q;
        if (!i_hold) begin
            wr_d   = alu2_q;
            alu2_d = alu1_q;
            alu1_d = dec_e;
            bp1_d  = bubble ? '0 : sel1;
            bp2_d  = bubble ? '0 : sel2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            alu1_q <= '0;
            alu2_q <= '0;
            wr_q   <= '0;
            bp1_q  <= '0;
            bp2_q  <= '0;
        end else begin
            alu1_q <= alu1_d;
            alu2_q <= alu2_d;
            wr_q   <= wr_d;
            bp1_q  <= bp1_d;
            bp2_q  <= bp2_d;
        end
    end

    assign o_bp1 = bp1_q;
    assign o_bp2 = bp2_q;
endmodule

// File: tb/tb_rv_bypass_ctrl.sv
// tb_rv_bypass_ctrl: directed stimulus checked against a pipeline-position model and literal expectations
module tb_rv_bypass_ctrl;
    logic       i_clk = 0, i_reset_n = 0, i_dec_valid = 0, i_dec_rd_wr = 0, i_dec_load = 0;
    logic       i_hold = 0, i_flush = 0, o_stall, chk_en = 0;
    logic [4:0] i_dec_rs1 = 0, i_dec_rs2 = 0, i_dec_rd = 0;
    logic [2:0] bp1, bp2, e_bp1 = 0, e_bp2 = 0;
    logic       m_v[3];
    logic [4:0] m_rd[3];
    logic       m_ld[3];
    int         n_tests = 0, n_fail = 0;

    rv_bypass_ctrl dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_dec_valid(i_dec_valid),
        .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2), .i_dec_rd(i_dec_rd),
        .i_dec_rd_wr(i_dec_rd_wr), .i_dec_load(i_dec_load), .i_hold(i_hold),
        .i_flush(i_flush), .o_bp1(bp1), .o_bp2(bp2), .o_stall(o_stall)
    );

    always #5 i_clk = ~i_clk;
    initial for (int k = 0; k < 3; k++) begin m_v[k] = 0; m_rd[k] = 0; m_ld[k] = 0; end

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // distance of the youngest in-flight writer of rs: 1 -> alu2, 2 -> write, 3 -> wr_back
    function automatic logic [2:0] msel(input logic [4:0] rs);
        for (int k = 0; k < 3; k++)
            if (rs != 0 && m_v[k] && m_rd[k] == rs) return 3'b100 >> k;
        return 3'b000;
    endfunction

    function automatic logic mstall();
        if (!i_dec_valid || i_flush || !m_v[0] || !m_ld[0]) return 0;
        return (i_dec_rs1 != 0 && m_rd[0] == i_dec_rs1) || (i_dec_rs2 != 0 && m_rd[0] == i_dec_rs2);
    endfunction

    always @(posedge i_clk) begin
        logic bub;
        if (!i_reset_n) begin
            for (int k = 0; k < 3; k++) m_v[k] = 0;
            e_bp1 = 0;
            e_bp2 = 0;
        end else if (!i_hold) begin
            bub = !i_dec_valid || i_flush || mstall();
            e_bp1 = bub ? 3'b000 : msel(i_dec_rs1);
            e_bp2 = bub ? 3'b000 : msel(i_dec_rs2);
            for (int k = 2; k > 0; k--) begin m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1]; end
            m_v[0]  = !bub && i_dec_rd_wr && i_dec_rd != 0;
            m_rd[0] = i_dec_rd;
            m_ld[0] = i_dec_load;
        end
    end

    always @(negedge i_clk) if (chk_en) begin
        check("model_stall", {2'b0, o_stall}, {2'b0, mstall()});
        check("model_bp1", bp1, e_bp1);
        check("model_bp2", bp2, e_bp2);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wr, input logic ld);
        i_dec_valid = v; i_dec_rs1 = rs1; i_dec_rs2 = rs2; i_dec_rd = rd;
        i_dec_rd_wr = wr; i_dec_load = ld;
        #1;
    endtask

    task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic ld);
        drive(1, rs1, rs2, rd, 1, ld);
        tick();
    endtask

    task automatic nops(input int n);
        drive(0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        check("reset_bp1", bp1, 3'b000);
        check("reset_bp2", bp2, 3'b000);
        check("reset_stall", {2'b0, o_stall}, 3'b000);
        i_reset_n = 1;
        chk_en = 1;
        // ADD x5 then ADD x6,x5,x1
        ins(1, 2, 5, 0);
        drive(1, 5, 1, 6, 1, 0);
        check("add_nostall", {2'b0, o_stall}, 3'b000);
        tick();
        check("add_bp1", bp1, 3'b100);
        check("add_bp2", bp2, 3'b000);
        nops(3);
        // LW x7 then ADD x8,x7,x7
        ins(2, 0, 7, 1);
        drive(1, 7, 7, 8, 1, 0);
        check("lu_stall", {2'b0, o_stall}, 3'b001);
        tick();
        check("lu_bubble_bp1", bp1, 3'b000);
        check("lu_retry_stall", {2'b0, o_stall}, 3'b000);
        tick();
        check("lu_retry_bp1", bp1, 3'b010);
        check("lu_retry_bp2", bp2, 3'b010);
        nops(3);
        // three writers of x9, then a reader
        ins(3, 0, 9, 0); ins(4, 0, 9, 0); ins(5, 0, 9, 0);
        ins(9, 0, 10, 0);
        check("youngest_bp1", bp1, 3'b100);
        nops(3);
        ins(3, 0, 9, 0);
        nops(2);
        ins(9, 0, 10, 0);
        check("dist3_bp1", bp1, 3'b001);
        nops(3);
        // x0 writer and reader
        ins(1, 0, 0, 0);
        ins(0, 0, 14, 0);
        check("x0_bp1", bp1, 3'b000);
        check("x0_bp2", bp2, 3'b000);
        nops(3);
        // hold for four cycles
        ins(0, 0, 11, 0);
        ins(11, 0, 12, 0);
        check("pre_hold_bp1", bp1, 3'b100);
        i_hold = 1;
        drive(1, 11, 12, 15, 1, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("hold_bp1", bp1, 3'b100);
            check("hold_bp2", bp2, 3'b000);
        end
        i_hold = 0;
        tick();
        check("release_bp1", bp1, 3'b010);
        check("release_bp2", bp2, 3'b100);
        nops(3);
        // load-use flushed
        ins(2, 0, 7, 1);
        i_flush = 1;
        drive(1, 7, 0, 8, 1, 0);
        check("flush_stall", {2'b0, o_stall}, 3'b000);
        tick();
        i_flush = 0;
        check("flush_bp1", bp1, 3'b000);
        drive(1, 7, 0, 8, 1, 0);
        check("after_flush_stall", {2'b0, o_stall}, 3'b000);
        tick();
        check("after_flush_bp1", bp1, 3'b010);
        nops(3);
        // no self match
        ins(13, 13, 13, 0);
        check("self_bp1", bp1, 3'b000);
        check("self_bp2", bp2, 3'b000);
        nops(3);
        // load-use then a second dependent while still held in stall
        ins(0, 0, 7, 1);
        i_hold = 1;
        drive(1, 0, 7, 8, 1, 0);
        check("hold_stall", {2'b0, o_stall}, 3'b001);
        tick();
        i_hold = 0;
        // reset during a stall
        drive(1, 0, 7, 8, 1, 0);
        check("pre_reset_stall", {2'b0, o_stall}, 3'b001);
        i_reset_n = 0;
        i_flush = 1;
        tick();
        i_flush = 0;
        check("rst_bp1", bp1, 3'b000);
        check("rst_bp2", bp2, 3'b000);
        check("rst_stall", {2'b0, o_stall}, 3'b000);
        i_reset_n = 1;
        tick();
        check("post_rst_bp2", bp2, 3'b000);
        nops(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rv_bypass_ctrl.md
RV_BYPASS_CTRL -- requirements
Module: rv_bypass_ctrl

Interface
REQ-001 Parameter: REG_W, 5, register-index width.
REQ-002 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 i_reset_n  in  1  reset, synchronous, active-low.
REQ-004 i_dec_valid  in  1  decode stage holds a real instruction.
REQ-005 i_dec_rs1 / i_dec_rs2  in  REG_W each  decode source registers; x0 = operand unused.
REQ-006 i_dec_rd  in  REG_W  decode destination register.
REQ-007 i_dec_rd_wr  in  1  decode instruction writes rd.
REQ-008 i_dec_load  in  1  decode instruction is a load; result is available from the write stage onward.
REQ-009 i_hold  in  1  global pipeline freeze, e.g. memory wait.
REQ-010 i_flush  in  1  kill the decode instruction (redirect).
REQ-011 o_bp1 / o_bp2  out  ctrl_rs_bp_t each  registered one-hot-or-zero bypass select {alu2, write, wr_back} for alu1 operands 1/2.
REQ-012 o_stall  out  1  combinational load-use stall request to fetch/decode.

Function
REQ-013 Tracker: 3 entries {valid, rd, load} for alu1, alu2 and write; the wr_back match uses the write entry before its shift.
REQ-014 Advance when i_hold=0: the write entry takes alu2, and alu2 takes alu1.
REQ-015 Decode-to-alu1 load on advance:
  - Normal: alu1 takes {i_dec_valid & i_dec_rd_wr & rd!=0, i_dec_rd, i_dec_load}.
  - Bubble (valid=0): on i_flush=1, o_stall=1 or i_dec_valid=0.
REQ-016 Match definition: rsN!=0, entry valid, entry rd==rsN.
REQ-017 Select computed in decode for the cycle the instruction enters alu1:
  - alu1-entry match -> alu2;
  - else alu2-entry match -> write;
  - else write-entry match -> wr_back;
  - else none.
  - Youngest match wins; at most one bit set.
REQ-018 o_bpN registers the REQ-017 select on advance when the instruction enters alu1; forced to zero when a bubble enters.
REQ-019 o_stall = i_dec_valid & ~i_flush & alu1 entry valid & alu1 load & (rs1 match | rs2 match).
REQ-020 Load-use latency: exactly one stall cycle. On the retry the load sits in alu2, so the select is write.
REQ-021 i_hold=1: all entries, o_bp1 and o_bp2 keep their values; o_stall is still evaluated.
REQ-022 i_flush and o_stall in the same cycle: flush wins; o_stall=0 and a bubble enters.
REQ-023 i_flush does not invalidate the alu1, alu2 or write entries; those instructions are older and retire.
REQ-024 rd=x0 never creates a valid entry.
REQ-025 A decode instruction whose rd equals its own rs does not self-match.

Reset
REQ-026 With i_reset_n=0 at a clock edge: all entry valid bits=0, o_bp1=o_bp2=0, so o_stall=0 the next cycle.
REQ-027 Reset overrides i_hold and i_flush.
REQ-028 Reset mid-stall: no stall persists after reset.

Structure
REQ-029 ctrl_rs_bp_t {alu2, write, wr_back} stays in the shared rv_defines package. The stage-entry struct is added there.
REQ-030 Optional sub-module rv_bypass_match: one per operand, maps rsN plus the 3 entries to a select.

Verification
REQ-031 ADD x5 followed by ADD x6,x5,x1 back-to-back -> o_bp1=alu2, o_bp2=0, o_stall=0.
REQ-032 LW x7 followed by ADD x8,x7,x7:
  - o_stall=1 for one cycle, and a bubble enters alu1;
  - on the retry o_bp1=o_bp2=write.
REQ-033 Writers of x9 at distances 1, 2 and 3 (three back-to-back writers), then an x9 reader -> alu2 (youngest wins). Writer at distance 3 only -> wr_back.
REQ-034 Writer to x0, then a reader of x0 -> o_bp=0.
REQ-035 i_hold=1 for 4 cycles mid-sequence -> o_bp and entries frozen, correct select after release.
REQ-036 LW x7 + i_flush on the dependent instruction -> o_stall=0, bubble enters.
REQ-037 i_reset_n=0 during a stall -> outputs zero at the next edge.
